// File: rtl/mc_control_if.sv
// Control bundle between the multicycle main FSM and the datapath/memory.
// The FSM takes the master side; the datapath takes the slave side.
interface mc_control_if #(
    parameter int unsigned FETCH_BEATS = 4
);
    logic [5:0]             op;
    logic                   zero;
    logic                   neg;
    logic                   mem_ready;

    logic                   memread;
    logic                   memwrite;
    logic                   alusrca;
    logic                   memtoreg;
    logic                   iord;
    logic                   regwrite;
    logic                   regdest;
    logic                   pcen;
    logic [1:0]             pcsource;
    logic [1:0]             alusrcb;
    logic [3:0]             aluop;
    logic [FETCH_BEATS-1:0] iwrite;
    logic                   halted;
    logic                   illegal_op;
    logic                   bus_error;
    logic [3:0]             state_o;

    modport master (
        input  op, zero, neg, mem_ready,
        output memread, memwrite, alusrca, memtoreg, iord, regwrite, regdest,
               pcen, pcsource, alusrcb, aluop, iwrite, halted, illegal_op, bus_error, state_o
    );

    modport slave (
        output op, zero, neg, mem_ready,
        input  memread, memwrite, alusrca, memtoreg, iord, regwrite, regdest,
               pcen, pcsource, alusrcb, aluop, iwrite, halted, illegal_op, bus_error, state_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle main control FSM: byte-serial fetch, mem_ready wait states, flag-qualified
// branches, memory watchdog with sticky bus error, halted/illegal status.
module mc_control_fsm #(
    parameter int unsigned FETCH_BEATS = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned TIMEOUT_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    mc_control_if.master  bus
);

    localparam int unsigned BeatW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1;
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(FETCH_BEATS - 1);
    localparam bit                   WdEn     = (TIMEOUT > 0);
    localparam logic [TIMEOUT_W-1:0] WdLast   = WdEn ? TIMEOUT_W'(TIMEOUT - 1) : '0;

    localparam logic [5:0] OpAddi = 6'b000000;
    localparam logic [5:0] OpSubi = 6'b000001;
    localparam logic [5:0] OpLw   = 6'b000010;
    localparam logic [5:0] OpSw   = 6'b000011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBlt  = 6'b000101;
    localparam logic [5:0] OpBgt  = 6'b000110;
    localparam logic [5:0] OpJ    = 6'b000111;
    localparam logic [5:0] OpExit = 6'b001000;

    localparam logic [3:0] AluAdd  = 4'b0010;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001;
    localparam logic [3:0] AluXor  = 4'b0011;
    localparam logic [3:0] AluXnor = 4'b0100;
    localparam logic [3:0] AluNor  = 4'b1100;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StJump   = 4'd2,
        StBranch = 4'd3,
        StExecA  = 4'd4,
        StMemAdr = 4'd6,
        StMemLw  = 4'd7,
        StMemSw  = 4'd8,
        StMemWb  = 4'd9,
        StExecI  = 4'd10,
        StHalt   = 4'd11
    } state_e;

    state_e               state_q, state_d;
    logic [BeatW-1:0]     beat_q, beat_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 bus_error_q, bus_error_d;
    logic [3:0]           alu_fn_q, alu_fn_d;

    logic is_atype;
    logic op_legal;
    logic waiting;
    logic [3:0] atype_fn;

    // A-type is 111xxx; 111111 is left undefined.
    always_comb begin
        is_atype = (bus.op[5:3] == 3'b111) && (bus.op[2:0] != 3'b111);
        op_legal = is_atype || (bus.op inside {OpAddi, OpSubi, OpLw, OpSw, OpBeq, OpBlt, OpBgt,
                                               OpJ, OpExit});
        atype_fn = AluAdd;
        case (bus.op[2:0])
            3'b000:  atype_fn = AluAdd;
            3'b001:  atype_fn = AluSub;
            3'b010:  atype_fn = AluXor;
            3'b011:  atype_fn = AluXnor;
            3'b100:  atype_fn = AluAnd;
            3'b101:  atype_fn = AluOr;
            3'b110:  atype_fn = AluNor;
            default: atype_fn = AluAdd;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        bus_error_d = bus_error_q;
        alu_fn_d    = alu_fn_q;

        unique case (state_q)
            StFetch: begin
                if (bus.mem_ready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StDecode;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StDecode: begin
                // EXEC_A/EXEC_I must not depend on op after it leaves DECODE.
                if (is_atype) begin
                    state_d  = StExecA;
                    alu_fn_d = atype_fn;
                end else begin
                    case (bus.op)
                        OpAddi: begin state_d = StExecI; alu_fn_d = AluAdd; end
                        OpSubi: begin state_d = StExecI; alu_fn_d = AluSub; end
                        OpLw, OpSw:          state_d = StMemAdr;
                        OpBeq, OpBlt, OpBgt: state_d = StBranch;
                        OpJ:                 state_d = StJump;
                        OpExit:              state_d = StHalt;
                        default:             state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: state_d = (bus.op == OpSw) ? StMemSw : StMemLw;
            StMemLw:  if (bus.mem_ready) state_d = StMemWb;
            StMemSw:  if (bus.mem_ready) state_d = StFetch;
            StExecA, StExecI, StMemWb, StBranch, StJump: state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase

        // A beat accepted in the expiry cycle takes priority over the timeout.
        waiting = (state_q inside {StFetch, StMemLw, StMemSw}) && !bus.mem_ready;
        if (WdEn && waiting && (wd_q == WdLast)) begin
            state_d     = StHalt;
            bus_error_d = 1'b1;
        end
        wd_d = (waiting && (state_d == state_q)) ? wd_q + TIMEOUT_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            beat_q      <= '0;
            wd_q        <= '0;
            bus_error_q <= 1'b0;
            alu_fn_q    <= AluAdd;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wd_q        <= wd_d;
            bus_error_q <= bus_error_d;
            alu_fn_q    <= alu_fn_d;
        end
    end

    // Outputs are a pure decode of state, gated off while reset is held.
    always_comb begin
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.iord       = 1'b0;
        bus.regwrite   = 1'b0;
        bus.regdest    = 1'b0;
        bus.pcen       = 1'b0;
        bus.pcsource   = 2'b00;
        bus.alusrcb    = 2'b00;
        bus.aluop      = 4'b0000;
        bus.iwrite     = '0;
        bus.halted     = 1'b0;
        bus.illegal_op = 1'b0;
        bus.bus_error  = 1'b0;
        bus.state_o    = 4'd0;

        if (!reset) begin
            bus.state_o   = state_q;
            bus.bus_error = bus_error_q;
            unique case (state_q)
                StFetch: begin
                    bus.memread = 1'b1;
                    bus.alusrcb = 2'b01;
                    bus.pcen    = bus.mem_ready;
                    for (int unsigned i = 0; i < FETCH_BEATS; i++) begin
                        bus.iwrite[i] = bus.mem_ready && (beat_q == BeatW'(i));
                    end
                end
                StDecode: begin
                    bus.alusrcb    = 2'b11;
                    bus.aluop      = AluAdd;
                    bus.illegal_op = !op_legal;
                end
                StExecA: begin
                    bus.alusrca  = 1'b1;
                    bus.regwrite = 1'b1;
                    bus.regdest  = 1'b1;
                    bus.aluop    = alu_fn_q;
                end
                StExecI: begin
                    bus.alusrca  = 1'b1;
                    bus.alusrcb  = 2'b10;
                    bus.regwrite = 1'b1;
                    bus.aluop    = alu_fn_q;
                end
                StMemAdr: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'b10;
                    bus.aluop   = AluAdd;
                end
                StMemLw: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                end
                StMemWb: begin
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                end
                StMemSw: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                end
                StBranch: begin
                    bus.alusrca  = 1'b1;
                    bus.aluop    = AluSub;
                    bus.pcsource = 2'b01;
                    bus.pcen     = ((bus.op == OpBeq) && bus.zero) ||
                                   ((bus.op == OpBlt) && bus.neg) ||
                                   ((bus.op == OpBgt) && !bus.zero && !bus.neg);
                end
                StJump: begin
                    bus.pcsource = 2'b10;
                    bus.pcen     = 1'b1;
                end
                StHalt:  bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Parametrised multicycle control unit; next generation of the processor's main control FSM.
- Adds:
  - byte-serial instruction fetch over FETCH_BEATS memory beats
  - mem_ready wait-state handshake
  - flag-qualified conditional branches
  - memory watchdog timeout with bus_error
  - explicit halted/illegal_op status
- Drives the existing multicycle datapath (PC, IR byte registers, register file, ALU muxes, memory).

Parameters:
- FETCH_BEATS, 4, memory beats (instruction bytes) per fetch; 1..4; width of iwrite.
- TIMEOUT, 255, max consecutive cycles waiting on mem_ready before bus error; 0 disables the watchdog.
- TIMEOUT_W, 8, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- op  input  6  opcode from instruction register
- zero  input  1  ALU result == 0 (valid in BRANCH)
- neg  input  1  ALU result negative (valid in BRANCH)
- mem_ready  input  1  memory accepts/returns current beat this cycle
- memread, memwrite, alusrca, memtoreg, iord, regwrite, regdest  output  1 each  datapath controls
- pcen  output  1  PC write enable
- pcsource  output  2  00 ALU, 01 ALUOut (branch target), 10 jump target
- alusrcb  output  2  00 B, 01 constant 1, 10 imm, 11 branch offset
- aluop  output  4  ALU function
- iwrite  output  FETCH_BEATS  one-hot IR byte write enable
- halted  output  1  core stopped (EXIT or bus error)
- illegal_op  output  1  undefined opcode decoded
- bus_error  output  1  sticky watchdog expiry
- state_o  output  4  current state, debug

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset effects: state<=FETCH, beat<=0, watchdog<=0, bus_error<=0.
- While reset is high, all outputs are forced 0; afterwards outputs decode from state. Outputs default 0 unless listed below.
- State codes: FETCH 0, DECODE 1, JUMP 2, BRANCH 3, EXEC_A 4, MEMADR 6, MEMLW 7, MEMSW 8, MEMWB 9, EXEC_I 10, HALT 11.
- Opcodes:
  - ADD 111000, SUB 111001, XOR 111010, XNOR 111011, AND 111100, OR 111101, NOR 111110
  - ADDI 000000, SUBI 000001, LW 000010, SW 000011
  - BEQ 000100, BLT 000101, BGT 000110, J 000111, EXIT 001000
  - All others illegal.
- aluop codes: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, XNOR 0100, NOR 1100.
- FETCH:
  - memread=1, alusrcb=01, pcsource=00.
  - iwrite[beat]=mem_ready (all ones when FETCH_BEATS=1).
  - pcen=mem_ready (PC+1 per byte).
  - On mem_ready: beat++ modulo FETCH_BEATS; after the last beat, go to DECODE.
- DECODE:
  - alusrcb=11, aluop=0010.
  - Next state: A-type->EXEC_A; ADDI/SUBI->EXEC_I; LW/SW->MEMADR; BEQ/BLT/BGT->BRANCH; J->JUMP; EXIT->HALT.
  - Illegal opcode: illegal_op=1 for this cycle only, next state FETCH.
- EXEC_A: alusrca=1, alusrcb=00, regwrite=1, regdest=1, aluop per op; next FETCH.
- EXEC_I: alusrca=1, alusrcb=10, regwrite=1, aluop 0010 (ADDI) / 0110 (SUBI); next FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=0010; next MEMLW (LW) or MEMSW (SW).
- MEMLW: memread=1, iord=1, held until mem_ready; then MEMWB.
- MEMWB: regwrite=1, memtoreg=1; next FETCH.
- MEMSW: memwrite=1, iord=1, held until mem_ready; then FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, aluop=0110, pcsource=01.
  - pcen = BEQ&zero | BLT&neg | BGT&~zero&~neg.
  - Next FETCH.
- JUMP: pcsource=10, pcen=1; next FETCH.
- HALT: halted=1, all enables 0; leaves only on reset.
- Watchdog:
  - Counts cycles in FETCH/MEMLW/MEMSW with mem_ready=0; clears on mem_ready or any state change.
  - When count==TIMEOUT-1 and mem_ready=0 (TIMEOUT>0): next state HALT, bus_error<=1 sticky until reset.
  - mem_ready in the expiry cycle wins: the beat is accepted.
- op is sampled only in DECODE, MEMADR and BRANCH (IR stable); changes elsewhere are ignored.
- Reset mid-fetch or mid-store: the access is abandoned, beat counter cleared, memwrite deasserted the same cycle.

Test Plan:
- FETCH_BEATS=4, mem_ready=1 constant, op=ADD -> iwrite 0001,0010,0100,1000 on consecutive cycles, pcen 4 cycles; DECODE, then EXEC_A with regwrite=1, regdest=1, aluop=0010; back to FETCH on cycle 7.
- LW with mem_ready low 3 cycles in MEMLW -> memread=iord=1 held 4 cycles, MEMWB one cycle with memtoreg=1, regwrite=1.
- BEQ zero=1 -> pcen=1, pcsource=01. BLT zero=1, neg=0 -> pcen=0. BGT zero=0, neg=0 -> pcen=1.
- TIMEOUT=8, mem_ready held 0 in FETCH -> after 8 cycles HALT, bus_error=1, halted=1; stays until reset; after reset, state_o=0.
- op=010101 in DECODE -> illegal_op=1 for exactly one cycle, next state FETCH, no regwrite/memwrite/pcen.
- EXIT -> HALT, halted=1, pcen=0 for 20 cycles. Reset asserted during MEMSW -> memwrite=0 same cycle, FETCH after release.
